// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with tear-free frame snapshot,
// per-digit blink, leading-zero blanking and 8-level PWM brightness.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       blink_en,
  input  logic [3:0] blink_mask,
  input  logic       lz_blank,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned LW = SW + 4;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_ph_q, blink_ph_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic            scan_wrap;
  logic            blink_wrap;
  logic [3:0]      bl;
  logic [LW-1:0]   win_lim;
  logic            on_win;
  logic            lit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;

    // Load the shadow on the 3->0 slot transition so a whole frame shows one snapshot.
    sh_d = sh_q;
    if (scan_wrap && (idx_q == 2'd3)) begin
      sh_d = {digit3, digit2, digit1, digit0};
    end

    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_ph_d  = blink_wrap ? ~blink_ph_q : blink_ph_q;
  end

  always_comb begin
    bl[3] = lz_blank & (sh_q[3] == 4'd0);
    bl[2] = bl[3] & (sh_q[2] == 4'd0);
    bl[1] = bl[2] & (sh_q[1] == 4'd0);
    bl[0] = 1'b0;

    win_lim = (LW'(bright) + LW'(1)) * LW'(SCAN_DIV);
    on_win  = ({4'b0000, scan_cnt_q} < (win_lim >> 3));

    lit = on_win & ~bl[idx_q] & ~(blink_en & blink_ph_q & blink_mask[idx_q]);

    an_d  = '1;
    seg_d = '1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(sh_q[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      sh_q        <= '0;
      an_q        <= '1;
      seg_q       <= '1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      sh_q        <= sh_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed phases plus random inputs, every cycle
// compared against a time-indexed behavioural model of the display.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int BD = 64;

  logic       clk;
  logic       rst;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       blink_en;
  logic [3:0] blink_mask;
  logic       lz_blank;
  logic [2:0] bright;
  logic [6:0] seg;
  logic [3:0] an;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: cycles since reset and the digits latched for the current frame.
  int n = 0;
  int msh [4] = '{0, 0, 0, 0};

  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  seg7_scan_driver #(
    .SCAN_DIV (SD),
    .BLINK_DIV(BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .blink_en  (blink_en),
    .blink_mask(blink_mask),
    .lz_blank  (lz_blank),
    .bright    (bright),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int in_digit(input int i);
    case (i)
      0:       return int'(digit0);
      1:       return int'(digit1);
      2:       return int'(digit2);
      default: return int'(digit3);
    endcase
  endfunction

  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    int  idx, cnt, ph;
    bit  lzb, win, blk;
    @(posedge clk);
    #1;
    ea = 4'hF;
    es = 7'h7F;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 4; i++) msh[i] = 0;
    end else begin
      idx = (n / SD) % 4;
      cnt = n % SD;
      ph  = (n / BD) % 2;
      lzb = 1'b0;
      if (lz_blank && idx > 0) begin
        lzb = 1'b1;
        for (int j = idx; j < 4; j++) if (msh[j] != 0) lzb = 1'b0;
      end
      win = (cnt < (((int'(bright) + 1) * SD) / 8));
      blk = blink_en && (ph == 1) && blink_mask[idx];
      if (win && !lzb && !blk) begin
        ea[idx] = 1'b0;
        es = seg_tab[msh[idx]];
      end
      n++;
      if (n % (4 * SD) == 0)
        for (int i = 0; i < 4; i++) msh[i] = in_digit(i);
    end
    vectors++;
    assert (an === ea) else begin
      miscompares++;
      $error("FAIL an n=%0d got %b exp %b", n, an, ea);
    end
    vectors++;
    assert (seg === es) else begin
      miscompares++;
      $error("FAIL seg n=%0d got %b exp %b", n, seg, es);
    end
    vectors++;
    assert ($countones(~an) <= 1) else begin
      miscompares++;
      $error("FAIL onehot n=%0d got %b exp at most one low", n, an);
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Advance until the model sits at the given position within a 4-slot frame.
  task automatic run_to(input int pos);
    int guard;
    guard = 0;
    while ((n % (4 * SD)) != pos && guard < 8 * SD) begin
      step();
      guard++;
    end
    vectors++;
    assert ((n % (4 * SD)) == pos) else begin
      miscompares++;
      $error("FAIL run_to got %0d exp %0d", n % (4 * SD), pos);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    digit3 = d3;
    digit2 = d2;
    digit1 = d1;
    digit0 = d0;
  endtask

  initial begin
    rst        = 1'b1;
    set_digits(4'h4, 4'h3, 4'h2, 4'h1);
    bright     = 3'd7;
    blink_en   = 1'b0;
    blink_mask = 4'b0000;
    lz_blank   = 1'b0;

    run(3);
    rst = 1'b0;
    run(3 * 4 * SD);

    run_to(SD + 3);
    digit0 = 4'h7;
    run(2 * 4 * SD);

    lz_blank = 1'b1;
    set_digits(4'h0, 4'h0, 4'h0, 4'h5);
    run(2 * 4 * SD);
    set_digits(4'h0, 4'h1, 4'h0, 4'h0);
    run(2 * 4 * SD);

    lz_blank   = 1'b0;
    set_digits(4'h4, 4'h3, 4'h2, 4'h1);
    blink_en   = 1'b1;
    blink_mask = 4'b0011;
    run(4 * BD);

    blink_en = 1'b0;
    bright   = 3'd1;
    run(2 * 4 * SD);
    bright   = 3'd0;
    run(2 * 4 * SD);

    bright = 3'd7;
    digit2 = 4'hC;
    run(2 * 4 * SD);
    run_to(2 * SD + 3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3 * 4 * SD);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 0) digit3 = 4'h0;
        if ($urandom_range(0, 2) == 0) digit2 = 4'h0;
      end
      if ($urandom_range(0, 31) == 0) begin
        blink_en   = 1'($urandom_range(0, 1));
        blink_mask = 4'($urandom_range(0, 15));
        lz_blank   = 1'($urandom_range(0, 1));
        bright     = 3'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    run(4 * SD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Four-digit, time-multiplexed seven-segment driver downstream of the stopwatch counter.
- Consumes four BCD digits (digit0 = seconds ones … digit3 = minutes tens) and produces active-low segment and anode drives for the board display.
- Derives its own scan and blink timing from the system clock.
- Adds tear-free digit snapshotting, per-digit blink masking, leading-zero blanking and 8-level PWM brightness.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (≥8)
BLINK_DIV, 25000000, clk cycles per blink half-period

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
digit0  input  4  BCD, rightmost digit (seconds ones)
digit1  input  4  BCD, seconds tens
digit2  input  4  BCD, minutes ones
digit3  input  4  BCD, leftmost digit (minutes tens)
blink_en  input  1  enable blinking of masked digits
blink_mask  input  4  bit i set → digit i blinks
lz_blank  input  1  enable leading-zero suppression
bright  input  3  brightness level, 0 dimmest … 7 full
seg  output  7  active-low segments, seg[0]=a … seg[6]=g
an  output  4  active-low anodes, an[i] drives digit i

Behaviour:
- Reset: scan_cnt=0, idx=0, blink_ph=0, shadow digits=0, an=4'b1111, seg=7'b1111111. Synchronous; applies even mid-slot.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, idx advances 0→1→2→3→0.
- Snapshot:
  - The shadow digits sh0..sh3 load digit0..3 on the cycle idx goes 3→0.
  - Input changes mid-frame never affect the current frame.
  - The first frame after reset displays zeros, or blanks under LZ.
- Blink: blink counter counts 0..BLINK_DIV-1; on wrap, blink_ph toggles. It is free-running and independent of blink_en.
- Leading-zero suppression (lz_blank=1):
  - bl3 = (sh3==0).
  - bl2 = bl3 & (sh2==0).
  - bl1 = bl2 & (sh1==0).
  - Digit 0 is never LZ-blanked.
  - With lz_blank=0, no digit is LZ-blanked.
- PWM window: on_win = (scan_cnt < ((bright+1)*SCAN_DIV)>>3). bright=7 gives the full slot lit.
- Lit condition for the current idx: on_win & !bl[idx] & !(blink_en & blink_ph & blink_mask[idx]).
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 → dash 0111111
- Outputs are registered, one cycle after the state that selects them:
  - lit → an = ~(4'b0001<<idx), seg = decode(sh[idx]).
  - not lit → an=4'b1111, seg=7'b1111111.
  - Never more than one anode low.
- Timing is exact at every boundary: no dead cycles at slot wrap, and the new idx appears on an one cycle after the wrap.
- Simultaneous events:
  - Snapshot and blink toggle on the same cycle: both take effect, and the new frame uses the new blink_ph.
  - rst has priority over all.

Test Plan:
- Reset/scan (SCAN_DIV=8, BLINK_DIV=64): hold rst 3 cycles, then release with digits=4'h1,2,3,4, bright=7, blink_en=0, lz_blank=0.
  - During rst: an=1111, seg=1111111.
  - First frame: all four digits show 0 (snapshot of reset zeros).
  - From the second frame: an=1110/seg=1111001 for 8 cycles, then an=1101/seg=0100100, an=1011/seg=0110000, an=0111/seg=0011001, repeating.
- Tear-free snapshot: change digit0 from 1 to 7 while idx=1 → the remainder of the frame is unchanged; the next frame's slot 0 shows seg=1111000.
- Leading-zero blanking: lz_blank=1, digits=0,0,0,5 (d3..d0) → slots 3,2,1 show an=1111; slot 0 shows 0010010. With digits 0,1,0,0 → only slot 3 is blank; slots 2,1,0 show 1,0,0.
- Blink: blink_en=1, blink_mask=4'b0011, BLINK_DIV=64.
  - blink_ph=0: all digits lit.
  - After 64 cycles (blink_ph=1): slots 0 and 1 dark, slots 2 and 3 lit.
  - The phase flips back every 64 cycles.
- Brightness: bright=1, SCAN_DIV=8 → each slot lit for exactly 2 of 8 cycles (an low for cycles 0–1 of the slot, delayed by 1 output cycle). bright=0 → 1 cycle lit.
- Illegal BCD and mid-operation reset:
  - digit2=4'hC → slot 2 shows seg=0111111.
  - Assert rst mid-slot 2 → next cycle an=1111; scanning restarts at idx=0 with scan_cnt=0.
